// File: rtl/kbd_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one command byte out on device clock edges and reports ACK or failure.
module kbd_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int PKT_TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_clk_in,
    input  logic       kbd_data_in,
    output logic       kbd_clk_oe,
    output logic       kbd_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RELEASE,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] INH_LAST   = INHIBIT_CYCLES - 1;
    localparam logic [31:0] START_BIT  = INHIBIT_CYCLES - INHIBIT_CYCLES / 2 - 1;
    localparam logic [31:0] START_LAST = START_TIMEOUT - 1;
    localparam logic [31:0] PKT_LAST   = PKT_TIMEOUT - 1;

    state_t      state;
    logic        clk_s1, clk_s2, clk_prev;
    logic        data_s1, data_s2;
    logic        clk_fall;
    logic        err_now;
    logic [9:0]  oe_q;
    logic [3:0]  bitcnt;
    logic [31:0] cnt;
    logic [31:0] pkt_cnt;

    // Lines idle high, so the synchronisers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= kbd_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= kbd_data_in;
            data_s2  <= data_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;

    always_comb begin
        err_now = 1'b0;
        case (state)
            S_RELEASE:   err_now = !clk_fall && (cnt == START_LAST);
            S_DATA:      err_now = !clk_fall && (pkt_cnt == PKT_LAST);
            S_ACK:       err_now = clk_fall ? data_s2 : (pkt_cnt == PKT_LAST);
            S_WAIT_IDLE: err_now = !(clk_s2 && data_s2) && (pkt_cnt == PKT_LAST);
            default:     err_now = 1'b0;
        endcase
    end

    // oe_q holds pull-low values in send order: d0..d7, parity, stop (never pulled).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            kbd_clk_oe  <= 1'b0;
            kbd_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            oe_q        <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            pkt_cnt     <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        oe_q        <= {1'b0, ^tx_data, ~tx_data};
                        cnt         <= '0;
                        bitcnt      <= '0;
                        tx_busy     <= 1'b1;
                        kbd_clk_oe  <= 1'b1;
                        kbd_data_oe <= 1'b0;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        kbd_clk_oe  <= 1'b0;
                        kbd_data_oe <= 1'b1;
                        cnt         <= '0;
                        state       <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (cnt >= START_BIT) begin
                            kbd_data_oe <= 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    cnt <= cnt + 32'd1;
                    if (clk_fall) begin
                        kbd_data_oe <= oe_q[0];
                        oe_q        <= oe_q >> 1;
                        bitcnt      <= 4'd1;
                        pkt_cnt     <= '0;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    pkt_cnt <= pkt_cnt + 32'd1;
                    if (clk_fall) begin
                        kbd_data_oe <= oe_q[0];
                        oe_q        <= oe_q >> 1;
                        bitcnt      <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) begin
                            state <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    pkt_cnt <= pkt_cnt + 32'd1;
                    if (clk_fall && !data_s2) begin
                        state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    pkt_cnt <= pkt_cnt + 32'd1;
                    if (clk_s2 && data_s2) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Any failure releases both lines and ends the transfer.
            if (err_now) begin
                kbd_clk_oe  <= 1'b0;
                kbd_data_oe <= 1'b0;
                tx_err      <= 1'b1;
                tx_busy     <= 1'b0;
                state       <= S_ERR;
            end
        end
    end

endmodule

// File: doc/kbd_tx.md
Name: kbd_tx

Overview:
PS/2 host-to-device transmitter; the outbound counterpart of the keyboard receiver. It sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 request-to-send sequence and reports acknowledge or failure. It drives the open-collector kbd_clk/kbd_data lines through active-high pull-low enables; the top level builds the tristates. tx_busy lets the top level gate the receiver during a transmission.

Parameters:
INHIBIT_CYCLES, 12000, cycles kbd_clk is held low before start (120 us at 100 MHz).
START_TIMEOUT, 1500000, max cycles from clock release to first device falling edge (15 ms).
PKT_TIMEOUT, 200000, max cycles from first falling edge to ACK sampled (2 ms).

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous reset, active-high
kbd_clk_in  in  1  raw PS/2 clock line level
kbd_data_in  in  1  raw PS/2 data line level
kbd_clk_oe  out  1  1 = pull PS/2 clock low
kbd_data_oe  out  1  1 = pull PS/2 data low
tx_data  in  8  command byte, sampled when tx_start is accepted
tx_start  in  1  one-cycle request; accepted only in IDLE
tx_busy  out  1  high from accept until tx_done/tx_err
tx_done  out  1  one-cycle pulse: byte sent, device ACKed
tx_err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (async): state IDLE; kbd_clk_oe=0, kbd_data_oe=0, tx_busy=0, tx_done=0, tx_err=0; counters cleared. Reset mid-transfer releases both lines immediately, with no pulse on done/err.
- Inputs pass through 2-flop synchronisers. A falling edge of kbd_clk is sync'd prev=1 and cur=0, 1-cycle pulse.
- Byte frame: start 0, d0..d7 LSB first, odd parity (~^byte), stop 1, then device ACK 0.
- IDLE: tx_start=1 latches tx_data and computes parity. Next cycle: INHIBIT, tx_busy=1.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES. During the last INHIBIT_CYCLES/2 cycles data_oe=1 as well (start bit). Then -> RELEASE.
- RELEASE: clk_oe=0 and data_oe stays 1. Wait for the first falling edge; if START_TIMEOUT expires -> ERR. On that edge, data_oe=~d0, bitcnt=1 -> DATA.
- DATA: each falling edge drives the next bit (data_oe = ~bit). Order after d0: d1..d7, then parity. On the falling edge after parity, data_oe=0 (stop bit) -> ACK.
- ACK: on the next falling edge, sample synced data. 0 -> WAIT_IDLE; 1 -> ERR (NACK).
- WAIT_IDLE: wait until synced clk=1 and data=1, then -> DONE.
- PKT_TIMEOUT runs from the first falling edge through WAIT_IDLE. Expiry in any of those states -> ERR.
- DONE: tx_done=1 for one cycle, tx_busy=0 -> IDLE.
- ERR: both oe=0, tx_err=1 for one cycle, tx_busy=0 -> IDLE.
- tx_busy drops in the same cycle as the done/err pulse. tx_start is ignored while busy, including in the DONE/ERR cycle.
- tx_done and tx_err are never asserted together.
- In INHIBIT, clock edges caused by device activity are ignored; the host wins.
- Total falling edges consumed: 11 (d0..d7, parity, stop, ack).

Test Plan:
- Send 0xED with a bench device model: clk_oe held low exactly INHIBIT_CYCLES. Device samples on rising edges 0,1,0,1,1,0,1,1,1 (start, d0..d7), then parity 1 and stop 1. ACK 0 -> one tx_done pulse, tx_err=0, tx_busy low afterwards.
- Send 0x01: parity bit sampled 0. Send 0xFF: parity 1. Send 0x00: parity 1. All ACKed, one tx_done each.
- Device drives data 1 at the ACK edge: tx_err pulse, no tx_done, both oe=0 in the error cycle.
- Device never clocks after release: tx_err exactly START_TIMEOUT cycles (±2 for sync) after clk_oe falls. Repeat with START_TIMEOUT overridden to 1000 for simulation speed.
- tx_start pulsed again mid-DATA with 0x55: ignored; the original byte completes unchanged.
- rst asserted during DATA after 4 bits: kbd_clk_oe=kbd_data_oe=0 in the same time step, tx_busy=0, no pulse. A following 0xF4 transmission completes normally.
